// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared types for the 5-stage core hazard controller: register
//           address width, forwarding select encoding, hazard FSM state
//           encoding and the per-stage destination tag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FW_RF    = 2'b00,
    FW_EXMEM = 2'b01,
    FW_MEMWB = 2'b10
  } forw_sel_e;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } haz_state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } pipe_tag_t;

  // A source depends on a tag only if it is actually read, is not x0, and the
  // tag holds a live register-writing instruction targeting it.
  function automatic logic tag_hit(input pipe_tag_t tag,
                                   input logic [REG_AW-1:0] src,
                                   input logic use_src);
    return tag.valid && tag.regwrite && (tag.rd == src) &&
           (src != '0) && use_src;
  endfunction

endpackage

`default_nettype wire

// File: rtl/haz_tag_cmp_s.sv
// ============================================================================
// Module  : haz_tag_cmp_s
// Brief   : Compares one ID source register against the ID/EX and EX/MEM
//           tags and priority-encodes the forwarding select (newest wins).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module haz_tag_cmp_s
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_use,
  input  pipe_tag_t         i_idex,
  input  pipe_tag_t         i_exmem,
  output logic              o_hit_idex,
  output logic              o_hit_exmem,
  output logic              o_load_idex,
  output forw_sel_e         o_sel
);

  // A load still in EX cannot be forwarded from EX/MEM next cycle, so the
  // memread flag only matters on the ID/EX tag.
  logic w_exmem_memread_unused;
  assign w_exmem_memread_unused = i_exmem.memread;

  assign o_hit_idex  = tag_hit(i_idex, i_src, i_use);
  assign o_hit_exmem = tag_hit(i_exmem, i_src, i_use);
  assign o_load_idex = o_hit_idex && i_idex.memread;

  // Producer in ID/EX lands in EX/MEM next cycle; EX/MEM lands in MEM/WB.
  always_comb begin
    o_sel = FW_RF;
    if (o_hit_idex)
      o_sel = FW_EXMEM;
    else if (o_hit_exmem)
      o_sel = FW_MEMWB;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_s.sv
// ============================================================================
// Module  : hazard_ctrl_s
// Brief   : Pipeline hazard controller. Tracks ID/EX, EX/MEM, MEM/WB
//           destination tags; issues stall, flush and registered operand
//           forwarding selects aligned with the instruction in EX.
//           Optional macro HAZ_PERF_CNT_EN adds stall/flush event counters.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_s
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              forw_en,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic [1:0]        forwA,
  output logic [1:0]        forwB,
  output logic              isForw_ON
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_STALL = 2'(STALL);
  localparam logic [1:0] ST_FLUSH = 2'(FLUSH);

  pipe_tag_t  r_idex, r_exmem, r_memwb;
  logic [1:0] r_state;
  logic [1:0] r_stall_cyc;
  forw_sel_e  r_forwA, r_forwB;
  logic       r_isforw;

  logic       w_hitA_idex, w_hitA_exmem, w_loadA;
  logic       w_hitB_idex, w_hitB_exmem, w_loadB;
  forw_sel_e  w_selA, w_selB;
  logic       w_hazard;
  pipe_tag_t  w_id_tag;

  // MEM/WB never hazards ID because the regfile is write-first; it is kept
  // only so the tag pipeline mirrors the datapath.
  logic w_memwb_unused;
  assign w_memwb_unused = ^r_memwb;

  assign w_id_tag = '{valid: id_valid, rd: id_rd,
                      regwrite: id_regwrite, memread: id_memread};

  haz_tag_cmp_s u_cmp_a (
    .i_src       (id_rs1),
    .i_use       (id_valid & id_use_rs1),
    .i_idex      (r_idex),
    .i_exmem     (r_exmem),
    .o_hit_idex  (w_hitA_idex),
    .o_hit_exmem (w_hitA_exmem),
    .o_load_idex (w_loadA),
    .o_sel       (w_selA)
  );

  haz_tag_cmp_s u_cmp_b (
    .i_src       (id_rs2),
    .i_use       (id_valid & id_use_rs2),
    .i_idex      (r_idex),
    .i_exmem     (r_exmem),
    .o_hit_idex  (w_hitB_idex),
    .o_hit_exmem (w_hitB_exmem),
    .o_load_idex (w_loadB),
    .o_sel       (w_selB)
  );

  // With forwarding only a load-use needs a bubble; without it any in-flight
  // producer blocks ID until it reaches MEM/WB.
  assign w_hazard = forw_en ? (w_loadA | w_loadB)
                            : (w_hitA_idex | w_hitA_exmem |
                               w_hitB_idex | w_hitB_exmem);

  assign flush_ifid = ex_branch_taken;
  assign flush_idex = ex_branch_taken;
  assign stall      = w_hazard & ~ex_branch_taken;

  assign forwA     = r_forwA;
  assign forwB     = r_forwB;
  assign isForw_ON = r_isforw;

  // Tag pipeline: bubble into ID/EX whenever ID is held or squashed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else begin
      r_memwb <= r_exmem;
      r_exmem <= r_idex;
      r_idex  <= (stall || flush_idex) ? '0 : w_id_tag;
    end
  end

  // Forward selects for the instruction entering EX; a bubble never forwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_forwA  <= FW_RF;
      r_forwB  <= FW_RF;
      r_isforw <= 1'b0;
    end else begin
      r_forwA  <= (forw_en && !stall && !ex_branch_taken) ? w_selA : FW_RF;
      r_forwB  <= (forw_en && !stall && !ex_branch_taken) ? w_selB : FW_RF;
      r_isforw <= forw_en;
    end
  end

  // Hazard FSM: flush overrides and cancels any stall in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_stall_cyc <= 2'd0;
    end else if (ex_branch_taken) begin
      r_state     <= ST_FLUSH;
      r_stall_cyc <= 2'd0;
    end else if (w_hazard && r_state != ST_FLUSH) begin
      r_state     <= ST_STALL;
      r_stall_cyc <= (r_state == ST_STALL && r_stall_cyc != 2'd2) ?
                     r_stall_cyc + 2'd1 : 2'd1;
    end else begin
      r_state     <= ST_RUN;
      r_stall_cyc <= 2'd0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Event counters; free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall)      stall_cnt <= stall_cnt + 32'd1;
      if (flush_ifid) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_s.sv
// ============================================================================
// Module  : tb_hazard_ctrl_s
// Brief   : Directed scoreboard bench for hazard_ctrl_s. Stimulus pushes the
//           hand-derived per-cycle expected outputs; a monitor pops and
//           compares them on the falling edge.
//           Macro HAZ_PERF_CNT_EN enables the counter checks.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_s;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       forw_en = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_regwrite = 1'b0, id_memread = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       stall, flush_ifid, flush_idex, isForw_ON;
  logic [1:0] forwA, forwB;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl_s dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .forw_en         (forw_en),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .forwA           (forwA),
    .forwB           (forwB),
    .isForw_ON       (isForw_ON)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       st;
    logic       fl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ifw;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  task automatic check(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // One clock of stimulus plus the expected outputs for that same cycle.
  task automatic step(input logic rn, fe, v,
                      input logic [4:0] r1, r2,
                      input logic u1, u2,
                      input logic [4:0] rd,
                      input logic rw, mr, br,
                      input logic es, ef,
                      input logic [1:0] ea, eb,
                      input logic ei);
    exp_t e;
    @(posedge clk);
    #1;
    cyc_no++;
    rst_n = rn; forw_en = fe; id_valid = v;
    id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; ex_branch_taken = br;
    e.cyc = cyc_no; e.st = es; e.fl = ef; e.fa = ea; e.fb = eb; e.ifw = ei;
    q.push_back(e);
  endtask

  // Monitor: every falling edge with a pending expectation is a comparison.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("stall",      e.cyc, 32'(stall),      32'(e.st));
        check("flush_ifid", e.cyc, 32'(flush_ifid), 32'(e.fl));
        check("flush_idex", e.cyc, 32'(flush_idex), 32'(e.fl));
        check("forwA",      e.cyc, 32'(forwA),      32'(e.fa));
        check("forwB",      e.cyc, 32'(forwB),      32'(e.fb));
        check("isForw_ON",  e.cyc, 32'(isForw_ON),  32'(e.ifw));
      end
    end
  end

  initial begin
    //    rn fe v  rs1 rs2 u1 u2 rd  rw mr br | st fl fa fb ifw
    // reset held two cycles, then released
    step(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);
    // add x5 ; sub x8,x5,x6 -> forwA=01 in sub's EX
    step(1, 1, 1, 1, 2, 1, 1, 5,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 5, 6, 1, 1, 8,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 1);
    // add x5 ; xor x9 ; sub x10,x5 -> forwA=10
    step(1, 1, 1, 1, 2, 1, 1, 5,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 2, 1, 1, 9,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 5, 6, 1, 1, 10, 1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 2, 0, 1);
    // lw x7 ; add x11,x3,x7 -> one stall, then forwB=10
    step(1, 1, 1, 1, 0, 1, 0, 7,  1, 1, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 3, 7, 1, 1, 11, 1, 0, 0,   1, 0, 0, 0, 1);
    step(1, 1, 1, 3, 7, 1, 1, 11, 1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 2, 1);
    // forwarding off: add x3 ; or x12,x3,x4 -> two stall cycles
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1);
    step(1, 0, 1, 1, 2, 1, 1, 3,  1, 0, 0,   0, 0, 0, 0, 0);
    step(1, 0, 1, 3, 4, 1, 1, 12, 1, 0, 0,   1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 4, 1, 1, 12, 1, 0, 0,   1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 4, 1, 1, 12, 1, 0, 0,   0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0);
    // lw x7 ; add reading x7 while a branch resolves -> flush wins over stall
    step(1, 1, 1, 1, 0, 1, 0, 7,  1, 1, 0,   0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 7, 1, 1, 13, 1, 0, 1,   0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1);
    // writer of x0 ; reader of x0 -> no hazard, no forward
    step(1, 1, 1, 1, 0, 1, 0, 0,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 2, 1, 1, 14, 1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1);
    // lw x9 ; invalid ID slot naming x9 -> no stall
    step(1, 1, 1, 1, 2, 1, 1, 9,  1, 1, 0,   0, 0, 0, 0, 1);
`ifdef HAZ_PERF_CNT_EN
    @(negedge clk);
    #1;
    check("stall_cnt", cyc_no, stall_cnt, 32'd3);
    check("flush_cnt", cyc_no, flush_cnt, 32'd1);
`endif
    step(1, 1, 0, 9, 9, 1, 1, 15, 1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1);
    // reset asserted during a load-use stall drops all tags
    step(1, 1, 1, 1, 0, 1, 0, 7,  1, 1, 0,   0, 0, 0, 0, 1);
    step(0, 1, 1, 1, 7, 1, 1, 13, 1, 0, 0,   1, 0, 0, 0, 1);
    step(1, 1, 1, 1, 7, 1, 1, 13, 1, 0, 0,   0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 1);
    // add x5 ; add x5 ; sub reading x5 -> newest producer (01) wins
    step(1, 1, 1, 1, 2, 1, 1, 5,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 2, 1, 1, 5,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 1, 5, 6, 1, 1, 8,  1, 0, 0,   0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 1, 0, 1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
